// File: rtl/e_match_sequencer.sv
// Stimulus/check sequencer for the e_counter match test: steps through the
// test cases, waits for the result to settle and scores it against a table.
module e_match_sequencer #(
    parameter int NUM_CASES     = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] result_i,
    output logic [7:0] test_case_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] pass_count_o,
    output logic [7:0] fail_count_o,
    output logic [7:0] first_fail_o
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_e;

    localparam logic [7:0] LastCase   = 8'(NUM_CASES - 1);
    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] NoFail     = 8'hFF;

    function automatic logic [7:0] expected(input logic [7:0] idx);
        logic [7:0] v;
        case (idx)
            8'd1:    v = 8'd2;
            8'd2:    v = 8'd3;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    state_e     state_q, state_d;
    logic [7:0] case_q, case_d;
    logic [7:0] pass_q, pass_d;
    logic [7:0] fail_q, fail_d;
    logic [7:0] ffail_q, ffail_d;
    logic [3:0] cnt_q, cnt_d;
    logic       done_q, done_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            case_q  <= 8'd0;
            pass_q  <= 8'd0;
            fail_q  <= 8'd0;
            ffail_q <= NoFail;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case_q  <= case_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            ffail_q <= ffail_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case_d  = case_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        ffail_d = ffail_q;
        cnt_d   = cnt_q;
        // done lags DONE entry by one edge and drops on the accepting start
        done_d  = (state_q == DONE) && !start_i;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = DRIVE;
                    case_d  = 8'd0;
                    pass_d  = 8'd0;
                    fail_d  = 8'd0;
                    ffail_d = NoFail;
                end
            end
            DRIVE: begin
                cnt_d   = SettleLoad;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CHECK: begin
                if (result_i == expected(case_q)) begin
                    if (pass_q != 8'hFF) pass_d = pass_q + 8'd1;
                end else begin
                    if (fail_q != 8'hFF) fail_d = fail_q + 8'd1;
                    if (ffail_q == NoFail) ffail_d = case_q;
                end
                if (case_q == LastCase) begin
                    state_d = DONE;
                end else begin
                    case_d  = case_q + 8'd1;
                    state_d = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o       = (state_q == DRIVE) || (state_q == SETTLE)
                    || (state_q == CHECK);
        done_o       = done_q;
        test_case_o  = case_q;
        pass_count_o = pass_q;
        fail_count_o = fail_q;
        first_fail_o = ffail_q;
    end

endmodule

// File: tb/tb_e_match_sequencer.sv
// Scoreboard bench for e_match_sequencer: default instance plus a
// SETTLE_CYCLES=1 instance driven by an e_counter model.
module tb_e_match_sequencer;

    localparam int N = 3;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] result = 8'd0;
    logic [7:0] tc, pc, fc, ff;
    logic       busy, done;

    logic       start1 = 1'b0;
    logic [7:0] result1;
    logic [7:0] tc1, pc1, fc1, ff1;
    logic       busy1, done1;

    int npass = 0;
    int ntotal = 0;
    int q[$];

    always #5 clk = ~clk;

    function automatic logic [7:0] tbl(input int idx);
        if (idx == 1) return 8'd2;
        if (idx == 2) return 8'd3;
        return 8'd0;
    endfunction

    assign result1 = tbl(int'(tc1));

    e_match_sequencer #(.NUM_CASES(N), .SETTLE_CYCLES(S)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .result_i(result),
        .test_case_o(tc), .busy_o(busy), .done_o(done),
        .pass_count_o(pc), .fail_count_o(fc), .first_fail_o(ff)
    );

    e_match_sequencer #(.NUM_CASES(N), .SETTLE_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .result_i(result1),
        .test_case_o(tc1), .busy_o(busy1), .done_o(done1),
        .pass_count_o(pc1), .fail_count_o(fc1), .first_fail_o(ff1)
    );

    task automatic test_reset;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        ntotal++;
        if ({tc, busy, done, pc, fc, ff} !== {8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 8'hFF})
            $display("FAIL reset_state: tc=%0d busy=%b done=%b pass=%0d fail=%0d ff=%h",
                     tc, busy, done, pc, fc, ff);
        else npass++;
        // reset wins over a simultaneous start
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        ntotal++;
        if (busy !== 1'b0) $display("FAIL reset_priority: busy=%b want 0", busy);
        else npass++;
    endtask

    task automatic do_run(input int mode, input bit disturb, input string tag);
        int ep = 0, ef = 0, done_e = 0, c, k, got;
        logic [7:0] eff = 8'hFF, rv;
        for (int i = 0; i < N; i++) begin
            q.push_back(i);
            rv = (mode == 1) ? 8'd0 : tbl(i);
            if (rv == tbl(i)) ep++;
            else begin
                ef++;
                if (eff == 8'hFF) eff = 8'(i);
            end
        end
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        ntotal++;
        if (done !== 1'b0 || pc !== 8'd0 || fc !== 8'd0 || busy !== 1'b1)
            $display("FAIL %s_start: done=%b pass=%0d fail=%0d busy=%b want 0/0/0/1",
                     tag, done, pc, fc, busy);
        else npass++;
        for (int e = 1; e <= 60 && done_e == 0; e++) begin
            c = e - 1;
            k = c / (S + 2);
            @(negedge clk);
            if (mode == 2 && (c % (S + 2)) != S + 1) result = 8'($urandom);
            else result = (mode == 1) ? 8'd0 : tbl(k);
            start = disturb && (c == S + 3);
            if ((c % (S + 2)) == S + 1 && k < N) begin
                got = q.pop_front();
                ntotal++;
                if (tc !== 8'(got) || busy !== 1'b1)
                    $display("FAIL %s_case: tc=%0d busy=%b want tc=%0d busy=1",
                             tag, tc, busy, got);
                else npass++;
            end
            @(posedge clk); #1; start = 1'b0;
            if (done === 1'b1) done_e = e;
        end
        ntotal++;
        if (done_e != N * (S + 2) + 1)
            $display("FAIL %s_done_cycle: got %0d want %0d", tag, done_e, N * (S + 2) + 1);
        else npass++;
        ntotal++;
        if (pc !== 8'(ep) || fc !== 8'(ef) || ff !== eff)
            $display("FAIL %s_counts: pass=%0d fail=%0d ff=%h want %0d/%0d/%h",
                     tag, pc, fc, ff, ep, ef, eff);
        else npass++;
        ntotal++;
        if (busy !== 1'b0 || tc !== 8'(N - 1) || q.size() != 0)
            $display("FAIL %s_end: busy=%b tc=%0d pending=%0d want 0/%0d/0",
                     tag, busy, tc, q.size(), N - 1);
        else npass++;
        q.delete();
    endtask

    task automatic test_mid_reset;
        @(negedge clk); result = 8'd0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        ntotal++;
        if (tc !== 8'd1 || busy !== 1'b1)
            $display("FAIL midrst_pre: tc=%0d busy=%b want 1/1", tc, busy);
        else npass++;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        ntotal++;
        if ({tc, busy, done, pc, fc, ff} !== {8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 8'hFF})
            $display("FAIL midrst_state: tc=%0d busy=%b done=%b pass=%0d fail=%0d ff=%h",
                     tc, busy, done, pc, fc, ff);
        else npass++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_settle1;
        int done_e = 0;
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        for (int e = 1; e <= 40 && done_e == 0; e++) begin
            @(posedge clk); #1;
            if (done1 === 1'b1) done_e = e;
        end
        ntotal++;
        if (done_e != 10) $display("FAIL settle1_done_cycle: got %0d want 10", done_e);
        else npass++;
        ntotal++;
        if (pc1 !== 8'd3 || fc1 !== 8'd0 || ff1 !== 8'hFF)
            $display("FAIL settle1_counts: pass=%0d fail=%0d ff=%h want 3/0/ff", pc1, fc1, ff1);
        else npass++;
    endtask

    initial begin
        test_reset();
        do_run(0, 1'b0, "basic");
        do_run(0, 1'b0, "restart");
        do_run(1, 1'b0, "zero");
        test_mid_reset();
        do_run(0, 1'b0, "after_rst");
        do_run(0, 1'b1, "busy_start");
        do_run(2, 1'b0, "garbage");
        test_settle1();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
